instruction_fetch: RTL and testbench

- Front-end pipeline stage directly upstream of the instruction decoder.
- Holds the PC and issues word reads to a synchronous instruction memory (1-cycle read latency).
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles redirects (taken branches, jumps) from execute and a sticky halt (EBREAK retired).

---
 rtl/instruction_fetch.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads to a 1-cycle synchronous
// instruction memory, buffers returned words and hands them to decode via valid/ready.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake: a word transfers to decode on every rising edge where
    // out_valid and out_ready are both high; out_instr/out_pc hold while stalled.

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          halted_q, halted_d;
    logic          fault_q, fault_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_pc_d    [DEPTH];

    logic          pop;
    logic          push;
    logic          redirect_take;
    logic          issue;
    logic [CW:0]   occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q;
    // A halt in the same cycle beats a redirect; once halted, redirects are ignored.
    assign redirect_take = redirect_valid & ~halted_q & ~halt;
    // Occupancy after this edge counts the word in flight, so a push always finds room.
    assign occupancy = (CW + 1)'(count_q) + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    assign issue     = reset_n & ~halted_q & ~halt & ~redirect_valid
                     & (occupancy < (CW + 1)'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign out_instr = fifo_instr_q[rd_ptr_q];
    assign out_pc    = fifo_pc_q[rd_ptr_q];
    assign fault     = fault_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_pc_d     = fifo_pc_q;

        if (redirect_take) begin
            // Flush: buffered words and the returning word belong to the old path.
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            inflight_d = 1'b0;
            pc_d       = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_d  = 1'b1;
                halted_d = 1'b1;
            end
        end else begin
            if (halt) begin
                halted_d = 1'b1;
            end
            if (push) begin
                fifo_instr_d[wr_ptr_q] = imem_rdata;
                fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
                wr_ptr_d               = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fifo_instr_q  <= fifo_instr_d;
            fifo_pc_q     <= fifo_pc_d;
        end
    end

    count_overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && !redirect_take && count_q == CW'(DEPTH)));
    count_underflow_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(pop && count_q == '0));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory model, scoreboard of expected PCs,
// and a monitor that checks every decode handshake against the queue.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .fault(fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ 32'hC0DE_0000;
    endfunction

    // Synchronous instruction memory, one cycle of read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples late in the low phase, after the driver has settled inputs.
    always @(negedge clk) begin
        #3;
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h, expected no transfer", out_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_pc", out_pc, mon_exp);
                check("out_instr", out_instr, mem_word(mon_exp));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_head(input logic [31:0] pc, input string name);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            step();
            if (out_valid === 1'b1 && out_pc === pc) found = 1'b1;
        end
        check(name, {31'b0, found}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        step();
        step();
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_imem_req", {31'b0, imem_req}, 32'd0);
        check("reset_imem_addr", imem_addr, RESET_PC);
        check("reset_fault", {31'b0, fault}, 32'd0);
        check("reset_out_instr", out_instr, 32'd0);
        check("reset_out_pc", out_pc, 32'd0);

        // Streaming, backpressure, redirect to 0x100, then halt draining 0x108/0x10C.
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(32'h000); exp_q.push_back(32'h004); exp_q.push_back(32'h008);
        exp_q.push_back(32'h00C); exp_q.push_back(32'h010);
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        exp_q.push_back(32'h108); exp_q.push_back(32'h10C);

        reset_n = 1'b1;
        #1;
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("no_valid_before_edge0", {31'b0, out_valid}, 32'd0);
        step();
        check("no_valid_after_edge0", {31'b0, out_valid}, 32'd0);
        check("pc_after_edge0", imem_addr, 32'h4);
        step();
        check("first_valid_after_edge1", {31'b0, out_valid}, 32'd1);

        wait_head(32'h8, "reach_pc_8");
        out_ready = 1'b0;
        repeat (5) step();
        check("bp_req_dropped", {31'b0, imem_req}, 32'd0);
        check("bp_valid_held", {31'b0, out_valid}, 32'd1);
        check("bp_pc_held", out_pc, 32'h8);
        check("bp_addr", imem_addr, 32'h10);
        out_ready = 1'b1;

        wait_head(32'h14, "reach_pc_14");
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("redir_req_low", {31'b0, imem_req}, 32'd0);
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("redir_flushed", {31'b0, out_valid}, 32'd0);
        check("redir_pc_loaded", imem_addr, 32'h100);
        step();
        check("redir_edge1_empty", {31'b0, out_valid}, 32'd0);
        step();
        check("redir_edge2_valid", {31'b0, out_valid}, 32'd1);
        check("redir_edge2_pc", out_pc, 32'h100);

        wait_head(32'h108, "reach_pc_108");
        halt      = 1'b1;
        out_ready = 1'b0;
        #1;
        check("halt_req_low", {31'b0, imem_req}, 32'd0);
        step();
        halt           = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        out_ready      = 1'b1;
        #1;
        check("halted_redir_req_low", {31'b0, imem_req}, 32'd0);
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        check("halt_drained", {31'b0, out_valid}, 32'd0);
        check("halt_no_req", {31'b0, imem_req}, 32'd0);
        check("halt_pc_frozen", imem_addr, 32'h110);
        check("phase1_queue_empty", exp_q.size(), 32'd0);

        // Reset from halted, fill the FIFO, then reset again mid-stream.
        reset_n = 1'b0;
        #1;
        check("reset_from_halt_valid", {31'b0, out_valid}, 32'd0);
        check("reset_from_halt_addr", imem_addr, RESET_PC);
        step();
        out_ready = 1'b0;
        reset_n   = 1'b1;
        repeat (4) step();
        check("full_valid", {31'b0, out_valid}, 32'd1);
        check("full_head_pc", out_pc, 32'h0);
        check("full_no_req", {31'b0, imem_req}, 32'd0);
        check("full_addr", imem_addr, 32'h8);
        reset_n = 1'b0;
        #1;
        check("async_reset_valid", {31'b0, out_valid}, 32'd0);
        check("async_reset_addr", imem_addr, RESET_PC);
        step();
        step();
        exp_q.push_back(32'h000);
        exp_q.push_back(32'h004);
        out_ready = 1'b1;
        reset_n   = 1'b1;

        // Misaligned redirect: sticky fault, no further fetches until reset.
        wait_head(32'h8, "restart_reach_pc_8");
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("fault_set", {31'b0, fault}, 32'd1);
        check("fault_flushed", {31'b0, out_valid}, 32'd0);
        check("fault_no_req", {31'b0, imem_req}, 32'd0);
        check("fault_pc_visible", imem_addr, 32'h102);
        repeat (5) step();
        check("fault_sticky", {31'b0, fault}, 32'd1);
        check("fault_still_no_req", {31'b0, imem_req}, 32'd0);
        check("fault_still_empty", {31'b0, out_valid}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("fault_cleared_by_reset", {31'b0, fault}, 32'd0);
        step();
        step();
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
